// File: rtl/proc_sequencer_if.sv
// ---------------------------------------------------------------------------
// proc_sequencer_if
//   Bundles the sequencer's control, program-ROM and processor-handshake
//   signals into one interface.
//
//   master modport : the sequencer side.
//   slave  modport : the environment side (ROM, processor, control source).
//
//   Signals
//     start      control -> seq   1-cycle pulse, restart program from address 0
//     step_mode  control -> seq   pause after every completed instruction
//     step_go    control -> seq   1-cycle pulse, release a paused sequencer
//     mem_addr   seq -> ROM       program ROM address (= PC)
//     mem_data   ROM -> seq       ROM word, valid one cycle after mem_addr
//     din        seq -> proc      processor DIN bus
//     run        seq -> proc      1-cycle pulse per issued instruction
//     done       proc -> seq      instruction complete
//     busy       seq -> control   sequencing in progress
//     halted     seq -> control   HALT opcode reached
//     error      seq -> control   Done watchdog expired (sticky)
//     instr_cnt  seq -> control   completed instructions since last Start
// ---------------------------------------------------------------------------
interface proc_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic              step_mode;
    logic              step_go;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data;
    logic [15:0]       din;
    logic              run;
    logic              done;
    logic              busy;
    logic              halted;
    logic              error;
    logic [15:0]       instr_cnt;

    modport master (
        input  start, step_mode, step_go, mem_data, done,
        output mem_addr, din, run, busy, halted, error, instr_cnt
    );

    modport slave (
        output start, step_mode, step_go, mem_data, done,
        input  mem_addr, din, run, busy, halted, error, instr_cnt
    );
endinterface

// File: rtl/proc_sequencer.sv
// ---------------------------------------------------------------------------
// proc_sequencer
//   Program sequencer for the simple 16-bit processor. Fetches instruction
//   words from a synchronous program ROM and issues them to the processor's
//   DIN/Run/Done handshake. An mvi instruction pulls its immediate from the
//   following ROM word, a HALT opcode stops sequencing without being issued,
//   single-step mode pauses after each completed instruction, and a watchdog
//   flags a processor that never answers with Done.
//
//   Ports
//     clk_i   rising-edge clock
//     rst_i   synchronous, active-high reset
//     bus     proc_sequencer_if.master (see interface for signal list)
//
//   Instruction word: [8:6] opcode, [5:3] X, [2:0] Y, [15:9] ignored.
// ---------------------------------------------------------------------------
module proc_sequencer #(
    parameter int       ADDR_W  = 5,
    parameter int       TIMEOUT = 15,
    parameter bit [2:0] MVI_OP  = 3'b001,
    parameter bit [2:0] HALT_OP = 3'b111
) (
    input  logic             clk_i,
    input  logic             rst_i,
    proc_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_FETCH_IMM = 4'd3,
        S_LATCH_IMM = 4'd4,
        S_ISSUE     = 4'd5,
        S_WAIT_DONE = 4'd6,
        S_GATE      = 4'd7,
        S_HALTED    = 4'd8,
        S_ERROR     = 4'd9
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ZERO   = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PC_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
    // Last watchdog value that still counts as "waiting"; wdog starts at 0
    // in the first WAIT_DONE cycle, so TIMEOUT cycles of waiting are allowed.
    localparam logic [7:0]        WDOG_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [15:0]       imm_q, imm_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        wdog_q, wdog_d;
    logic [15:0]       din_q, din_d;
    logic              run_q;
    logic              busy_q;
    logic              halted_q;
    logic              error_q;

    function automatic logic [2:0] opcode(input logic [15:0] word);
        return word[8:6];
    endfunction

    // Next-state, PC, IR/IMM capture, instruction counter and watchdog.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        imm_d   = imm_q;
        cnt_d   = cnt_q;
        wdog_d  = wdog_q;
        case (state_q)
            // Idle-like states accept Start; Start elsewhere is ignored.
            S_IDLE, S_HALTED, S_ERROR: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                    pc_d    = PC_ZERO;
                    cnt_d   = 16'h0000;
                end else begin
                    state_d = state_q;
                end
            end
            // ROM registers mem_addr (= PC) at the end of this cycle.
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d = bus.mem_data;
                if (opcode(bus.mem_data) == HALT_OP) begin
                    // PC stays on the HALT word so it remains visible.
                    state_d = S_HALTED;
                end else if (opcode(bus.mem_data) == MVI_OP) begin
                    // Immediate lives in the next word; PC wraps naturally.
                    state_d = S_FETCH_IMM;
                    pc_d    = pc_q + PC_ONE;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_FETCH_IMM: begin
                state_d = S_LATCH_IMM;
            end
            S_LATCH_IMM: begin
                imm_d   = bus.mem_data;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                wdog_d  = 8'd0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                wdog_d = wdog_q + 8'd1;
                // Done is checked first so it beats a same-cycle expiry.
                if (bus.done) begin
                    pc_d  = pc_q + PC_ONE;
                    cnt_d = cnt_q + 16'd1;
                    if (bus.step_mode) begin
                        state_d = S_GATE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = S_WAIT_DONE;
                end
            end
            // Leaving step mode releases the gate as well as StepGo does.
            S_GATE: begin
                if (bus.step_go || !bus.step_mode) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_GATE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // DIN value for the cycle we are about to enter.
    always_comb begin
        din_d = 16'h0000;
        case (state_d)
            S_ISSUE: begin
                din_d = ir_d;
            end
            // During the wait the processor reads the mvi immediate from DIN.
            S_WAIT_DONE: begin
                if (opcode(ir_d) == MVI_OP) begin
                    din_d = imm_d;
                end else begin
                    din_d = 16'h0000;
                end
            end
            default: begin
                din_d = 16'h0000;
            end
        endcase
    end

    // State, datapath and Moore outputs decoded from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            pc_q     <= PC_ZERO;
            ir_q     <= 16'h0000;
            imm_q    <= 16'h0000;
            cnt_q    <= 16'h0000;
            wdog_q   <= 8'd0;
            din_q    <= 16'h0000;
            run_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            imm_q    <= imm_d;
            cnt_q    <= cnt_d;
            wdog_q   <= wdog_d;
            din_q    <= din_d;
            run_q    <= (state_d == S_ISSUE);
            busy_q   <= !((state_d == S_IDLE) || (state_d == S_HALTED) ||
                          (state_d == S_ERROR));
            halted_q <= (state_d == S_HALTED);
            error_q  <= (state_d == S_ERROR);
        end
    end

    assign bus.mem_addr  = pc_q;
    assign bus.din       = din_q;
    assign bus.run       = run_q;
    assign bus.busy      = busy_q;
    assign bus.halted    = halted_q;
    assign bus.error     = error_q;
    assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_proc_sequencer
//   Drives proc_sequencer with a small program ROM and a processor stand-in
//   that answers Run with Done after a chosen delay. Expected issue order,
//   DIN values and final state come from walking the ROM program directly.
// ---------------------------------------------------------------------------
module tb_proc_sequencer;
    localparam int          AW     = 2;
    localparam int          DEPTH  = 1 << AW;
    localparam int          TMO    = 15;
    localparam logic [15:0] HALT_W = 16'h01C0;

    logic clk = 1'b0;
    logic rst;

    proc_sequencer_if #(.ADDR_W(AW)) bus ();

    proc_sequencer #(
        .ADDR_W (AW),
        .TIMEOUT(TMO),
        .MVI_OP (3'b001),
        .HALT_OP(3'b111)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    logic [15:0] rom [0:DEPTH-1];
    logic [15:0] exp_din [$];
    logic [15:0] exp_imm [$];
    bit          exp_halt;
    int          exp_pc;
    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    int          fail_cnt = 0;
    string       cur = "reset";

    always #5 clk = ~clk;

    // Synchronous program ROM: data one cycle after the address.
    always @(posedge clk) bus.mem_data <= rom[bus.mem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s/%s: observed %0h expected %0h", cur, tag, obs, exp);
        end
    endtask

    // Walk the program as the processor would see it.
    task automatic build_model(input int limit);
        int          pc;
        logic [15:0] w;
        pc = 0;
        exp_din.delete();
        exp_imm.delete();
        exp_halt = 1'b0;
        exp_pc   = 0;
        for (int n = 0; n <= limit; n++) begin
            w = rom[pc];
            if (w[8:6] == 3'b111) begin
                exp_halt = 1'b1;
                exp_pc   = pc;
                break;
            end
            if (n == limit) break;
            exp_din.push_back(w);
            if (w[8:6] == 3'b001) begin
                pc = (pc + 1) % DEPTH;
                exp_imm.push_back(rom[pc]);
            end else begin
                exp_imm.push_back(16'h0000);
            end
            pc = (pc + 1) % DEPTH;
        end
    endtask

    // Start the program and play the processor. dly = Done delay in cycles
    // after Run (0 = never). A program that does not halt within `limit`
    // instructions is aborted by Reset + Done in its last WAIT cycle.
    task automatic exec_prog(input int dly, input bit step, input bit stray, input int limit);
        int t;
        int lat;
        int n;
        bit seen;
        build_model(limit);
        n = exp_din.size();
        bus.step_mode = step;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        check("start_addr",   bus.mem_addr,  32'd0);
        check("start_busy",   bus.busy,      32'd1);
        check("start_error",  bus.error,     32'd0);
        check("start_halted", bus.halted,    32'd0);
        check("start_cnt",    bus.instr_cnt, 32'd0);
        for (int i = 0; i < n; i++) begin
            lat  = (exp_din[i][8:6] == 3'b001) ? 5 : 3;
            t    = 1;
            seen = 1'b0;
            while (!seen && t <= 8) begin
                if (bus.run === 1'b1) seen = 1'b1;
                else begin
                    @(negedge clk);
                    t++;
                end
            end
            check("run_latency", t, lat);
            if (!seen) return;
            check("issue_din", bus.din, exp_din[i]);
            if (stray) begin
                bus.done  = 1'b1;
                bus.start = 1'b1;
            end
            if (dly == 0) begin
                for (int j = 1; j <= TMO; j++) begin
                    @(negedge clk);
                    bus.done  = 1'b0;
                    bus.start = 1'b0;
                    if (j == 1) check("wait_run", bus.run, 32'd0);
                    if (j == TMO) begin
                        check("pre_err", bus.error, 32'd0);
                        check("pre_busy", bus.busy, 32'd1);
                    end
                end
                @(negedge clk);
                check("err_set",  bus.error, 32'd1);
                check("err_busy", bus.busy,  32'd0);
                check("err_run",  bus.run,   32'd0);
                return;
            end
            for (int j = 1; j <= dly; j++) begin
                @(negedge clk);
                bus.start = 1'b0;
                if (j == 1) check("imm_din", bus.din, exp_imm[i]);
                check("wait_run", bus.run, 32'd0);
                if (i == n - 1 && !exp_halt) begin
                    rst      = 1'b1;
                    bus.done = 1'b1;
                    @(negedge clk);
                    rst      = 1'b0;
                    bus.done = 1'b0;
                    check("rst_run",    bus.run,       32'd0);
                    check("rst_din",    bus.din,       32'd0);
                    check("rst_busy",   bus.busy,      32'd0);
                    check("rst_halted", bus.halted,    32'd0);
                    check("rst_error",  bus.error,     32'd0);
                    check("rst_addr",   bus.mem_addr,  32'd0);
                    check("rst_cnt",    bus.instr_cnt, 32'd0);
                    return;
                end
                bus.done = (j == dly);
            end
            @(negedge clk);
            bus.done = 1'b0;
            check("instr_cnt", bus.instr_cnt, i + 1);
            if (step) begin
                check("gate_busy", bus.busy, 32'd1);
                for (int g = 1; g <= 3; g++) begin
                    check("gate_run", bus.run, 32'd0);
                    if (g < 3) @(negedge clk);
                end
                bus.step_go = 1'b1;
                @(negedge clk);
                bus.step_go = 1'b0;
            end
        end
        if (exp_halt) begin
            @(negedge clk);
            check("pre_halt", bus.halted, 32'd0);
            @(negedge clk);
            check("halted",      bus.halted,    32'd1);
            check("halt_busy",   bus.busy,      32'd0);
            check("halt_run",    bus.run,       32'd0);
            check("halt_pc",     bus.mem_addr,  exp_pc);
            check("halt_cnt",    bus.instr_cnt, n);
        end
    endtask

    initial begin
        logic [15:0] w;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.step_mode = 1'b0;
        bus.step_go   = 1'b0;
        bus.done      = 1'b0;
        for (int a = 0; a < DEPTH; a++) rom[a] = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        check("reset_run",    bus.run,       32'd0);
        check("reset_din",    bus.din,       32'd0);
        check("reset_busy",   bus.busy,      32'd0);
        check("reset_halted", bus.halted,    32'd0);
        check("reset_error",  bus.error,     32'd0);
        check("reset_addr",   bus.mem_addr,  32'd0);
        check("reset_cnt",    bus.instr_cnt, 32'd0);
        rst = 1'b0;

        // mvi R0,#5 then HALT
        cur = "mvi_halt";
        rom[0] = 16'h0040; rom[1] = 16'h0005; rom[2] = HALT_W; rom[3] = 16'h0000;
        exec_prog(2, 1'b0, 1'b0, 6);

        // two single-word instructions, Done 3 cycles after Run
        cur = "two_instr";
        rom[0] = 16'h0008; rom[1] = 16'h0081; rom[2] = HALT_W; rom[3] = 16'h0000;
        exec_prog(3, 1'b0, 1'b0, 6);

        // Done on the last permitted watchdog cycle still wins
        cur = "done_at_limit";
        exec_prog(TMO, 1'b0, 1'b1, 6);

        // single-step through three instructions
        cur = "step";
        rom[0] = 16'h0008; rom[1] = 16'h0081; rom[2] = 16'h000A; rom[3] = HALT_W;
        exec_prog(1, 1'b1, 1'b0, 6);

        // Done never arrives: watchdog error, then restart from ERROR
        cur = "timeout";
        exec_prog(0, 1'b0, 1'b0, 6);
        cur = "restart";
        rom[0] = 16'h0040; rom[1] = 16'h0005; rom[2] = HALT_W; rom[3] = 16'h0000;
        exec_prog(2, 1'b0, 1'b0, 6);

        // mvi at the last address takes its immediate from address 0;
        // the fifth instruction is aborted by Reset with Done in the same cycle
        cur = "wrap";
        rom[0] = 16'h1234; rom[1] = 16'h0001; rom[2] = 16'h000A; rom[3] = 16'h0040;
        exec_prog(2, 1'b0, 1'b0, 5);

        // random programs, Done delays and modes
        cur = "random";
        for (int r = 0; r < 24; r++) begin
            for (int a = 0; a < DEPTH; a++) begin
                w = 16'($urandom);
                w[8:6] = 3'($urandom_range(0, 7));
                rom[a] = w;
            end
            exec_prog($urandom_range(1, TMO), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 6);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
